// File: rtl/afifo_push_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one async-FIFO write port,
// granting bursts of up to BURST_LEN words and sequencing a fixed-length FIFO flush.
module afifo_push_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 9,
  parameter int BURST_LEN    = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                          clock0,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FLUSH_REQ,
  input  logic                          Full,
  input  logic                          Almost_Full,
  input  logic                          Overrun_Error,
  output logic                          PUSH,
  output logic [DATA_WIDTH-1:0]         DIN,
  output logic                          Async_Flush,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic                          OVERRUN_STICKY,
  output logic [1:0]                    state_dbg
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  aflush_q, aflush_d;
  logic                  sticky_q, sticky_d;

  logic                  sel_found;
  logic [PW-1:0]         sel_idx;
  logic [PW-1:0]         idx;
  logic [PW-1:0]         next_ptr;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;

  // Scan downward so the requester closest to ptr_q (ascending, wrapping) wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (REQ_VALID[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  assign owner_valid = REQ_VALID[owner_q];
  assign owner_data  = REQ_DATA[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr    = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

  assign REQ_READY = (reset_n && state_q == S_GRANT && !Full && !Almost_Full && !FLUSH_REQ)
                     ? grant_q : '0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    push_d   = 1'b0;
    din_d    = din_q;
    sticky_d = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (FLUSH_REQ) begin
          state_d  = S_FLUSH;
          fcnt_d   = '0;
          sticky_d = 1'b0;
        end else if (sel_found) begin
          state_d = S_GRANT;
          owner_d = sel_idx;
          grant_d = NUM_REQ'(1) << sel_idx;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (FLUSH_REQ) begin
          state_d  = S_FLUSH;
          ptr_d    = next_ptr;
          grant_d  = '0;
          fcnt_d   = '0;
          sticky_d = 1'b0;
        end else if (Full || Almost_Full) begin
          state_d = S_GRANT;
        end else if (owner_valid) begin
          push_d = 1'b1;
          din_d  = owner_data;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(BURST_LEN - 1)) begin
            state_d = S_IDLE;
            ptr_d   = next_ptr;
            grant_d = '0;
          end
        end else begin
          state_d = S_IDLE;
          ptr_d   = next_ptr;
          grant_d = '0;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == FW'(FLUSH_CYCLES - 1)) begin
          state_d = S_IDLE;
          ptr_d   = '0;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A fresh overrun outranks the clear on flush entry.
    if (Overrun_Error) sticky_d = 1'b1;
    aflush_d = (state_d == S_FLUSH);
  end

  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      push_q   <= 1'b0;
      din_q    <= '0;
      aflush_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      push_q   <= push_d;
      din_q    <= din_d;
      aflush_q <= aflush_d;
      sticky_q <= sticky_d;
    end
  end

  assign PUSH           = push_q;
  assign DIN            = din_q;
  assign Async_Flush    = aflush_q;
  assign GRANT          = grant_q;
  assign OVERRUN_STICKY = sticky_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_afifo_push_arbiter.sv
// Directed bench for afifo_push_arbiter: a vector table for round-robin bursts and
// hand-written sequences for short bursts, stalls, flush aborts, resets and overrun.
module tb_afifo_push_arbiter;
  localparam int NR = 4;
  localparam int DW = 9;

  logic              clock0 = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              flush_req, full, almost_full, overrun_error;
  logic              push;
  logic [DW-1:0]     din;
  logic              async_flush;
  logic [NR-1:0]     grant;
  logic              overrun_sticky;
  logic [1:0]        state_dbg;

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  afifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(4), .FLUSH_CYCLES(3)) dut (
    .clock0(clock0), .reset_n(reset_n), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_READY(req_ready), .FLUSH_REQ(flush_req), .Full(full), .Almost_Full(almost_full),
    .Overrun_Error(overrun_error), .PUSH(push), .DIN(din), .Async_Flush(async_flush),
    .GRANT(grant), .OVERRUN_STICKY(overrun_sticky), .state_dbg(state_dbg)
  );

  always #5 clock0 = ~clock0;

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] grant;
    logic [NR-1:0] ready;
    logic          push;
    logic [DW-1:0] din;
  } vec_t;

  vec_t vtab[12];

  localparam logic [NR*DW-1:0] D   = {9'h133, 9'h122, 9'h111, 9'h100};
  localparam logic [NR*DW-1:0] D2A = {9'h133, 9'h1A5, 9'h111, 9'h100};
  localparam logic [NR*DW-1:0] D2B = {9'h133, 9'h0F3, 9'h111, 9'h100};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step%0d %s: got %0h want %0h", step_no, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then compare outputs 1ns later.
  task automatic step(input logic rst, input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                      input logic f, input logic af, input logic fl, input logic ovr,
                      input logic [NR-1:0] eg, input logic [NR-1:0] er, input logic ep,
                      input logic [DW-1:0] ed, input logic ea, input logic es);
    @(negedge clock0);
    reset_n = rst; req_valid = v; req_data = d; full = f; almost_full = af;
    flush_req = fl; overrun_error = ovr;
    #1;
    step_no++;
    check("grant", 32'(grant), 32'(eg));
    check("ready", 32'(req_ready), 32'(er));
    check("push", 32'(push), 32'(ep));
    if (ep) check("din", 32'(din), 32'(ed));
    check("async_flush", 32'(async_flush), 32'(ea));
    check("sticky", 32'(overrun_sticky), 32'(es));
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; req_data = D; full = 1'b0; almost_full = 1'b0;
    flush_req = 1'b0; overrun_error = 1'b0;

    vtab[0]  = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 9'h000};
    vtab[1]  = '{4'b0101, 4'b0001, 4'b0001, 1'b0, 9'h000};
    vtab[2]  = '{4'b0101, 4'b0001, 4'b0001, 1'b1, 9'h100};
    vtab[3]  = '{4'b0101, 4'b0001, 4'b0001, 1'b1, 9'h100};
    vtab[4]  = '{4'b0101, 4'b0001, 4'b0001, 1'b1, 9'h100};
    vtab[5]  = '{4'b0101, 4'b0000, 4'b0000, 1'b1, 9'h100};
    vtab[6]  = '{4'b0101, 4'b0100, 4'b0100, 1'b0, 9'h000};
    vtab[7]  = '{4'b0101, 4'b0100, 4'b0100, 1'b1, 9'h122};
    vtab[8]  = '{4'b0101, 4'b0100, 4'b0100, 1'b1, 9'h122};
    vtab[9]  = '{4'b0101, 4'b0100, 4'b0100, 1'b1, 9'h122};
    vtab[10] = '{4'b0101, 4'b0000, 4'b0000, 1'b1, 9'h122};
    vtab[11] = '{4'b0101, 4'b0001, 4'b0001, 1'b0, 9'h000};

    // Reset state
    step(0, 4'b0000, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0, 0, 0);
    step(0, 4'b0000, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0, 0, 0);
    check("din_rst", 32'(din), 32'h0);
    check("state_rst", 32'(state_dbg), 32'h0);

    // Alternating bursts between requesters 0 and 2
    for (int i = 0; i < 12; i++)
      step(1, vtab[i].valid, D, 0,0,0,0, vtab[i].grant, vtab[i].ready, vtab[i].push, vtab[i].din, 0, 0);

    // Reset mid-burst: ready drops while reset is low
    step(0, 4'b0101, D, 0,0,0,0, 4'b0001, 4'b0000, 1, 9'h100, 0, 0);

    // Requester 2 sends two words then drops valid
    step(1, 4'b0100, D2A, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0, 0, 0);
    check("din_after_rst", 32'(din), 32'h0);
    step(1, 4'b0100, D2A, 0,0,0,0, 4'b0100, 4'b0100, 0, 9'h0,   0, 0);
    step(1, 4'b0100, D2B, 0,0,0,0, 4'b0100, 4'b0100, 1, 9'h1A5, 0, 0);
    step(1, 4'b0000, D2B, 0,0,0,0, 4'b0100, 4'b0100, 1, 9'h0F3, 0, 0);
    step(1, 4'b0000, D,   0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   0, 0);
    // Pointer now 3: requester 3 beats requester 0
    step(1, 4'b1001, D,   0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   0, 0);
    step(1, 4'b1001, D,   0,0,0,0, 4'b1000, 4'b1000, 0, 9'h0,   0, 0);
    step(0, 4'b1001, D,   0,0,0,0, 4'b1000, 4'b0000, 1, 9'h133, 0, 0);

    // After reset the pointer restarts at 0; Almost_Full stalls after 2 beats
    step(1, 4'b1001, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   0, 0);
    step(1, 4'b0001, D, 0,0,0,0, 4'b0001, 4'b0001, 0, 9'h0,   0, 0);
    step(1, 4'b0001, D, 0,0,0,0, 4'b0001, 4'b0001, 1, 9'h100, 0, 0);
    step(1, 4'b0001, D, 0,1,0,0, 4'b0001, 4'b0000, 1, 9'h100, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 4'b0001, D, 0,1,0,0, 4'b0001, 4'b0000, 0, 9'h0, 0, 0);
    step(1, 4'b0001, D, 0,0,0,0, 4'b0001, 4'b0001, 0, 9'h0,   0, 0);
    step(1, 4'b0001, D, 0,0,0,0, 4'b0001, 4'b0001, 1, 9'h100, 0, 0);
    step(1, 4'b0001, D, 0,0,0,0, 4'b0000, 4'b0000, 1, 9'h100, 0, 0);
    step(1, 4'b0001, D, 0,0,0,0, 4'b0001, 4'b0001, 0, 9'h0,   0, 0);
    step(0, 4'b0011, D, 0,0,0,0, 4'b0001, 4'b0000, 1, 9'h100, 0, 0);

    // Overrun pulse, then flush pulse on beat 3 aborts burst and clears sticky
    step(1, 4'b0011, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   0, 0);
    step(1, 4'b0011, D, 0,0,0,1, 4'b0001, 4'b0001, 0, 9'h0,   0, 0);
    step(1, 4'b0011, D, 0,0,0,0, 4'b0001, 4'b0001, 1, 9'h100, 0, 1);
    step(1, 4'b0011, D, 0,0,1,0, 4'b0001, 4'b0000, 1, 9'h100, 0, 1);
    step(1, 4'b0011, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   1, 0);
    step(1, 4'b0011, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   1, 0);
    step(1, 4'b0011, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   1, 0);
    step(1, 4'b0011, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   0, 0);
    step(1, 4'b0011, D, 0,0,1,0, 4'b0001, 4'b0000, 0, 9'h0,   0, 0);

    // Reset in the middle of a flush
    step(1, 4'b0011, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   1, 0);
    step(0, 4'b0011, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   1, 0);
    step(1, 4'b0011, D, 0,0,0,0, 4'b0000, 4'b0000, 0, 9'h0,   0, 0);
    step(1, 4'b0011, D, 0,0,0,0, 4'b0001, 4'b0001, 0, 9'h0,   0, 0);
    // Full also blocks ready while the grant is held
    step(1, 4'b0011, D, 1,0,0,0, 4'b0001, 4'b0000, 1, 9'h100, 0, 0);
    step(1, 4'b0011, D, 0,0,0,0, 4'b0001, 4'b0001, 0, 9'h0,   0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afifo_push_arbiter.md
AFIFO_PUSH_ARBITER -- requirements
Module: afifo_push_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one FIFO write port.
REQ-002 SHALL have parameter DATA_WIDTH, default 9, FIFO write width (matches WR_DATA_WIDTH).
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum beats per grant.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 3, Async_Flush pulse length in cycles.
REQ-005 SHALL have port clock0, input, 1, the single clock; all logic rises on clock0.
REQ-006 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have port REQ_VALID, input, NUM_REQ, per-requester word valid.
REQ-008 SHALL have port REQ_DATA, input, NUM_REQ*DATA_WIDTH, requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port REQ_READY, output, NUM_REQ, per-requester accept (combinational).
REQ-010 SHALL have port FLUSH_REQ, input, 1, level request to flush the FIFO.
REQ-011 SHALL have port Full, input, 1, FIFO full flag.
REQ-012 SHALL have port Almost_Full, input, 1, FIFO almost-full flag.
REQ-013 SHALL have port Overrun_Error, input, 1, FIFO overrun flag.
REQ-014 SHALL have port PUSH, output, 1, registered FIFO push strobe.
REQ-015 SHALL have port DIN, output, DATA_WIDTH, registered FIFO write data.
REQ-016 SHALL have port Async_Flush, output, 1, registered FIFO flush.
REQ-017 SHALL have port GRANT, output, NUM_REQ, one-hot current owner, zero when none.
REQ-018 SHALL have port OVERRUN_STICKY, output, 1, latched Overrun_Error.

Function
REQ-019 SHALL implement states IDLE, GRANT, FLUSH; state, pointer, beat counter, flush counter all registered.
REQ-020 SHALL in IDLE with FLUSH_REQ=1 go to FLUSH next cycle, taking priority over any REQ_VALID.
REQ-021 SHALL in IDLE with FLUSH_REQ=0 and any REQ_VALID=1 grant the first valid requester at or after rr pointer (ascending, wrapping), load GRANT, clear beat count, go to GRANT.
REQ-022 SHALL drive REQ_READY[i]=1 only when state=GRANT, GRANT[i]=1, Full=0, Almost_Full=0, FLUSH_REQ=0.
REQ-023 SHALL on a transfer (REQ_VALID[i]&REQ_READY[i]) register PUSH=1 and DIN=REQ_DATA slice i for exactly one cycle in the following cycle; PUSH=0 otherwise.
REQ-024 SHALL count transfers; end grant after the transfer making count=BURST_LEN.
REQ-025 SHALL end grant in any GRANT cycle where REQ_VALID of owner is 0 (no transfer).
REQ-026 SHALL on grant end set pointer=(owner+1) mod NUM_REQ, clear GRANT, go to IDLE (one idle bubble between bursts).
REQ-027 SHALL while Full or Almost_Full is 1 hold GRANT and count (stall, not end grant).
REQ-028 SHALL in GRANT with FLUSH_REQ=1 abort the burst without transfer, advance pointer as in REQ-026, go to FLUSH.
REQ-029 SHALL in FLUSH drive Async_Flush=1 for exactly FLUSH_CYCLES consecutive cycles, REQ_READY all 0, then go to IDLE with pointer=0; FLUSH_REQ still high re-enters FLUSH.
REQ-030 SHALL set OVERRUN_STICKY when Overrun_Error=1; clear only on reset or FLUSH entry.

Reset
REQ-031 SHALL on reset_n=0 at a clock0 edge set state=IDLE, pointer=0, counts=0, GRANT=0, PUSH=0, DIN=0, Async_Flush=0, OVERRUN_STICKY=0, aborting any burst or flush in progress.
REQ-032 SHALL keep REQ_READY=0 during and on the first cycle after reset release.

Verification
REQ-033 SHALL cover: REQ_VALID=4'b0101 continuously, FIFO empty -> GRANT 0001 for 4 PUSHes, bubble, GRANT 0100 for 4 PUSHes, back to 0001.
REQ-034 SHALL cover: requester 2 alone sends data 9'h1A5,9'h0F3 then drops valid -> PUSH two cycles, DIN 1A5 then 0F3 each one cycle late, grant ends, pointer=3.
REQ-035 SHALL cover: Almost_Full high 5 cycles mid-burst after 2 beats -> no PUSH for 5 cycles, GRANT held, remaining 2 beats complete after release.
REQ-036 SHALL cover: FLUSH_REQ pulsed 1 cycle during beat 3 -> no transfer that cycle, Async_Flush high exactly 3 cycles, then IDLE, next grant from requester 0.
REQ-037 SHALL cover: reset_n low 1 cycle mid-burst and mid-flush -> all outputs 0 next cycle, next grant starts at requester 0.
REQ-038 SHALL cover: Overrun_Error 1-cycle pulse -> OVERRUN_STICKY stays 1 until a FLUSH entry clears it.
